// File: rtl/motion_pkg.sv
// motion_pkg: shared types and constants for the motion compensator.
//   BLK, WIN, MV_OFFSET : block edge, search-window edge, vector bias that
//                         maps mv=-8 onto window column/row 0
//   pixel_t, mv_t, addr_s_t, pix_idx_t : pixel, signed vector component,
//                         search-memory address, raster index
//   mc_entry_t          : one output-FIFO entry {pixel, raster index}
//   mc_state_t          : compensator control states
//   sat_pixel()         : prediction + residual, clamped to the pixel range
package motion_pkg;

    localparam int BLK       = 16;
    localparam int WIN       = 32;
    localparam int MV_OFFSET = 8;

    typedef logic [7:0]        pixel_t;
    typedef logic signed [3:0] mv_t;
    typedef logic [9:0]        addr_s_t;
    typedef logic [7:0]        pix_idx_t;

    typedef struct packed {
        pixel_t   pix;
        pix_idx_t idx;
    } mc_entry_t;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} mc_state_t;

    // Sum is formed at 10 bits signed so that 255 + 255 and 0 - 256 both fit.
    function automatic pixel_t sat_pixel(input pixel_t pred, input logic signed [8:0] res);
        logic signed [9:0] sum;
        sum = $signed({2'b00, pred}) + 10'(res);
        if (sum < 0)
            return 8'h00;
        else if (sum > 10'sd255)
            return 8'hFF;
        else
            return pixel_t'(sum[7:0]);
    endfunction

endpackage

// File: rtl/mc_out_fifo.sv
// mc_out_fifo: 2-deep {pixel, idx} FIFO between the search-memory read
// return and the pixel stream output.
//   clock, reset_n : clock, asynchronous active-low reset (pointers/count only)
//   push, push_data: write one entry
//   pop            : remove the head entry (caller only pops when count != 0)
//   count          : number of entries held (0..2)
//   head           : oldest entry, meaningful while count != 0
module mc_out_fifo
    import motion_pkg::*;
(
    input  logic      clock,
    input  logic      reset_n,
    input  logic      push,
    input  mc_entry_t push_data,
    input  logic      pop,
    output logic [1:0] count,
    output mc_entry_t head
);

    mc_entry_t mem [2];
    logic      wr_ptr;
    logic      rd_ptr;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push)
                wr_ptr <= ~wr_ptr;
            if (pop)
                rd_ptr <= ~rd_ptr;
            // push and pop together leave the count unchanged
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/motion_compensator.sv
// motion_compensator: fetches the 16x16 predicted block addressed by a
// motion vector from the 32x32 search memory and streams its 256 pixels in
// raster order over valid/ready.
//   clock, reset_n      : clock, asynchronous active-low reset
//   start               : request, sampled only while idle
//   motionX, motionY    : signed vector, latched on an accepted start
//   AddressS / S        : search-memory read port; S carries the data for the
//                         address registered at the previous edge
//   residual_in         : signed residual added to the prediction (only when
//                         MOTION_COMP_RESIDUAL_EN is defined)
//   pixel_out/_valid/_idx, pixel_ready : output stream
//   busy, completed     : block in progress / one-cycle end-of-block pulse
// Build option: MOTION_COMP_RESIDUAL_EN adds residual_in and a clamped sum.
module motion_compensator #(
    parameter int BLK   = 16,
    parameter int WIN   = 32,
    parameter int PIX_W = 8,
    parameter int MV_W  = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic signed [MV_W-1:0] motionX,
    input  logic signed [MV_W-1:0] motionY,
    output logic [9:0]             AddressS,
    input  logic [PIX_W-1:0]       S,
`ifdef MOTION_COMP_RESIDUAL_EN
    input  logic signed [PIX_W:0]  residual_in,
`endif
    output logic [PIX_W-1:0]       pixel_out,
    output logic                   pixel_valid,
    input  logic                   pixel_ready,
    output logic [7:0]             pixel_idx,
    output logic                   busy,
    output logic                   completed
);
    import motion_pkg::*;

    localparam int LAST_IDX = BLK * BLK - 1;

    mc_state_t state;
    mv_t       mv_x;
    mv_t       mv_y;
    pix_idx_t  issue_idx;
    logic      vld_p0;
    pix_idx_t  idx_p0;
    logic [1:0] fifo_count;
    mc_entry_t head;
    mc_entry_t push_entry;
    logic      pop;
    logic      issue;
    logic      fifo_drained;
    logic [5:0] x_sum;
    logic [5:0] y_sum;

    // Window coordinates at 6 bits: 0..15 + (-8..7) + 8 stays within 0..30.
    assign y_sum = 6'(issue_idx[7:4]) + 6'(mv_y) + 6'(MV_OFFSET);
    assign x_sum = 6'(issue_idx[3:0]) + 6'(mv_x) + 6'(MV_OFFSET);

    assign pixel_valid = (fifo_count != 2'd0);
    assign pop         = pixel_valid & pixel_ready;

    // A slot freed by this cycle's pop counts as free, so a read returning in
    // one cycle keeps the stream at one pixel per cycle with only two entries.
    assign issue = (state == FETCH) &&
                   ((int'(fifo_count) - int'(pop) + int'(vld_p0)) < 2);

    assign fifo_drained = !vld_p0 && ((int'(fifo_count) - int'(pop)) == 0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            AddressS  <= '0;
            issue_idx <= '0;
            vld_p0    <= 1'b0;
            busy      <= 1'b0;
            completed <= 1'b0;
        end else begin
            vld_p0 <= issue;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy      <= 1'b1;
                        issue_idx <= '0;
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    if (issue) begin
                        AddressS  <= addr_s_t'(int'(y_sum) * WIN + int'(x_sum));
                        issue_idx <= issue_idx + 8'd1;
                        if (issue_idx == 8'(LAST_IDX))
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (fifo_drained) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        completed <= 1'b1;
                    end
                end
                DONE: begin
                    completed <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stage p0: the vector and the raster index travel with the issued read.
    always_ff @(posedge clock) begin
        if (state == IDLE && start) begin
            mv_x <= mv_t'(motionX);
            mv_y <= mv_t'(motionY);
        end
        if (issue)
            idx_p0 <= issue_idx;
    end

    // Stage p1: returned memory data is captured into the output FIFO.
    assign push_entry = '{pix: pixel_t'(S), idx: idx_p0};

    mc_out_fifo u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (vld_p0),
        .push_data (push_entry),
        .pop       (pop),
        .count     (fifo_count),
        .head      (head)
    );

    // Outputs read zero whenever the FIFO is empty.
`ifdef MOTION_COMP_RESIDUAL_EN
    assign pixel_out = pixel_valid ? PIX_W'(sat_pixel(head.pix, residual_in)) : '0;
`else
    assign pixel_out = pixel_valid ? PIX_W'(head.pix) : '0;
`endif
    assign pixel_idx = pixel_valid ? head.idx : '0;

endmodule
